// File: rtl/time_keeper.sv
// Wall-clock time base: prescales master_clk to a one-second tick and keeps hh:mm:ss.
// Define TIME_KEEPER_12H_EN for 12-hour mode with a PM flag. The default build is 24-hour mode.
module time_keeper #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       master_clk,
    input  logic       master_rst_n,
    input  logic       set_minutes,
    input  logic       set_hours,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       second_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
`ifdef TIME_KEEPER_12H_EN
    localparam logic [4:0] HOURS_RST = 5'd12;
`else
    localparam logic [4:0] HOURS_RST = 5'd0;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       seconds_q, seconds_d;
    logic [5:0]       minutes_q, minutes_d;
    logic [4:0]       hours_q, hours_d;
    logic             pm_q, pm_d;
    logic             second_tick_q, second_tick_d;

    logic tick;
    logic live_tick;
    logic sec_wrap;
    logic min_wrap;
    logic hour_inc;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        div_cnt_d     = div_cnt_q + 1'b1;
        seconds_d     = seconds_q;
        minutes_d     = minutes_q;
        hours_d       = hours_q;
        pm_d          = pm_q;

        tick      = (div_cnt_q == DIV_LAST);
        // A minute set restarts the second, so it swallows any tick in the same cycle.
        live_tick = tick && !set_minutes;
        sec_wrap  = (seconds_q == 6'd59);
        min_wrap  = (minutes_q == 6'd59);
        second_tick_d = live_tick;

        if (tick || set_minutes) begin
            div_cnt_d = '0;
        end

        if (set_minutes) begin
            seconds_d = '0;
            minutes_d = min_wrap ? 6'd0 : minutes_q + 6'd1;
        end else if (live_tick) begin
            seconds_d = sec_wrap ? 6'd0 : seconds_q + 6'd1;
            if (sec_wrap) begin
                minutes_d = min_wrap ? 6'd0 : minutes_q + 6'd1;
            end
        end

        // A set and a carry arriving together still advance hours by exactly one.
        hour_inc = set_hours || (live_tick && sec_wrap && min_wrap);
        if (hour_inc) begin
`ifdef TIME_KEEPER_12H_EN
            if (hours_q == 5'd11) begin
                hours_d = 5'd12;
                pm_d    = !pm_q;
            end else if (hours_q == 5'd12) begin
                hours_d = 5'd1;
            end else begin
                hours_d = hours_q + 5'd1;
            end
`else
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            pm_d    = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            div_cnt_q     <= '0;
            seconds_q     <= '0;
            minutes_q     <= '0;
            hours_q       <= HOURS_RST;
            pm_q          <= 1'b0;
            second_tick_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            seconds_q     <= seconds_d;
            minutes_q     <= minutes_d;
            hours_q       <= hours_d;
            pm_q          <= pm_d;
            second_tick_q <= second_tick_d;
        end
    end

    assign seconds     = seconds_q;
    assign minutes     = minutes_q;
    assign hours       = hours_q;
    assign pm          = pm_q;
    assign second_tick = second_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4; 12-hour scenarios run when TIME_KEEPER_12H_EN is defined.
module tb_time_keeper;

    localparam int TICK_DIV = 4;
`ifdef TIME_KEEPER_12H_EN
    localparam int RST_H = 12;
`else
    localparam int RST_H = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_minutes = 1'b0;
    logic       set_hours = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic       second_tick;

    int errors = 0;
    int checks = 0;

    time_keeper #(.TICK_DIV(TICK_DIV)) dut (
        .master_clk   (clk),
        .master_rst_n (rst_n),
        .set_minutes  (set_minutes),
        .set_hours    (set_hours),
        .seconds      (seconds),
        .minutes      (minutes),
        .hours        (hours),
        .pm           (pm),
        .second_tick  (second_tick)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Release lands between edges; the next edge counted by step() is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
    endtask

    // Reset, pulse hours hp times, leave minutes at m with prescaler cleared, then run s seconds.
    task automatic preset(input int hp, input int m, input int s);
        do_reset();
        if (hp > 0) begin
            set_hours = 1'b1;
            step(hp);
            set_hours = 1'b0;
        end
        set_minutes = 1'b1;
        step(60 + m);
        set_minutes = 1'b0;
        step(TICK_DIV * s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'(RST_H), 6'd0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %0d:%0d:%0d pm=%b tick=%b, expected %0d:0:0 pm=0 tick=0",
                     hours, minutes, seconds, pm, second_tick, RST_H);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic       exp_tick;
            logic [5:0] exp_sec;
            step(1);
            exp_tick = (i % TICK_DIV) == 0;
            exp_sec  = 6'(i / TICK_DIV);
            checks++;
            if ({hours, minutes, seconds, pm, second_tick} !== {5'(RST_H), 6'd0, exp_sec, 1'b0, exp_tick}) begin
                errors++;
                $display("FAIL count_cycle%0d: got %0d:%0d:%0d pm=%b tick=%b, expected %0d:0:%0d pm=0 tick=%b",
                         i, hours, minutes, seconds, pm, second_tick, RST_H, exp_sec, exp_tick);
            end
        end
    endtask

    task automatic test_coincidence();
        preset(5, 59, 59);
        step(TICK_DIV - 1);
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd5, 6'd59, 6'd59, 1'b0}) begin
            errors++;
            $display("FAIL pre_coinc: got %0d:%0d:%0d tick=%b, expected 5:59:59 tick=0",
                     hours, minutes, seconds, second_tick);
        end
        set_hours = 1'b1;
        step(1);
        set_hours = 1'b0;
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd6, 6'd0, 6'd0, 1'b1}) begin
            errors++;
            $display("FAIL coinc_set_hours: got %0d:%0d:%0d tick=%b, expected 6:0:0 tick=1",
                     hours, minutes, seconds, second_tick);
        end

        preset(5, 10, 20);
        step(TICK_DIV - 1);
        set_minutes = 1'b1;
        step(1);
        set_minutes = 1'b0;
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd5, 6'd11, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL coinc_set_minutes: got %0d:%0d:%0d tick=%b, expected 5:11:0 tick=0",
                     hours, minutes, seconds, second_tick);
        end
        step(TICK_DIV - 1);
        checks++;
        if ({seconds, second_tick} !== {6'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_early: got sec=%0d tick=%b, expected sec=0 tick=0", seconds, second_tick);
        end
        step(1);
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd5, 6'd11, 6'd1, 1'b1}) begin
            errors++;
            $display("FAIL restart_tick: got %0d:%0d:%0d tick=%b, expected 5:11:1 tick=1",
                     hours, minutes, seconds, second_tick);
        end

        preset(5, 59, 10);
        set_minutes = 1'b1;
        set_hours   = 1'b1;
        step(1);
        set_minutes = 1'b0;
        set_hours   = 1'b0;
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd6, 6'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL both_sets: got %0d:%0d:%0d tick=%b, expected 6:0:0 tick=0",
                     hours, minutes, seconds, second_tick);
        end
    endtask

`ifndef TIME_KEEPER_12H_EN
    task automatic test_rollover();
        preset(23, 59, 0);
        step(TICK_DIV * 59);
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'd23, 6'd59, 6'd59, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL roll_235959: got %0d:%0d:%0d pm=%b tick=%b, expected 23:59:59 pm=0 tick=1",
                     hours, minutes, seconds, pm, second_tick);
        end
        step(TICK_DIV - 1);
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
            errors++;
            $display("FAIL roll_hold: got %0d:%0d:%0d tick=%b, expected 23:59:59 tick=0",
                     hours, minutes, seconds, second_tick);
        end
        step(1);
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'd0, 6'd0, 6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL roll_000000: got %0d:%0d:%0d pm=%b tick=%b, expected 0:0:0 pm=0 tick=1",
                     hours, minutes, seconds, pm, second_tick);
        end
    endtask

    task automatic test_set_pulses();
        preset(10, 59, 30);
        set_minutes = 1'b1;
        step(1);
        set_minutes = 1'b0;
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd10, 6'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL set_min_wrap: got %0d:%0d:%0d tick=%b, expected 10:0:0 tick=0",
                     hours, minutes, seconds, second_tick);
        end
        // Prescaler keeps running during the 14 hour pulses: ticks land on edges 4, 8, 12.
        set_hours = 1'b1;
        step(14);
        set_hours = 1'b0;
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd0, 6'd0, 6'd3, 1'b0}) begin
            errors++;
            $display("FAIL set_hours_wrap: got %0d:%0d:%0d tick=%b, expected 0:0:3 tick=0",
                     hours, minutes, seconds, second_tick);
        end
    endtask
`else
    task automatic test_12h();
        do_reset();
        checks++;
        if ({hours, minutes, seconds, pm} !== {5'd12, 6'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL h12_reset: got %0d:%0d:%0d pm=%b, expected 12:0:0 pm=0", hours, minutes, seconds, pm);
        end
        set_hours = 1'b1;
        step(11);
        set_hours = 1'b0;
        checks++;
        if ({hours, minutes, seconds, pm} !== {5'd11, 6'd0, 6'd2, 1'b0}) begin
            errors++;
            $display("FAIL h12_eleven: got %0d:%0d:%0d pm=%b, expected 11:0:2 pm=0", hours, minutes, seconds, pm);
        end
        set_hours = 1'b1;
        step(1);
        set_hours = 1'b0;
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'd12, 6'd0, 6'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL h12_pm: got %0d:%0d:%0d pm=%b tick=%b, expected 12:0:3 pm=1 tick=1",
                     hours, minutes, seconds, pm, second_tick);
        end
        set_hours = 1'b1;
        step(11);
        set_hours = 1'b0;
        set_minutes = 1'b1;
        step(119);
        set_minutes = 1'b0;
        step(TICK_DIV * 59);
        checks++;
        if ({hours, minutes, seconds, pm} !== {5'd11, 6'd59, 6'd59, 1'b1}) begin
            errors++;
            $display("FAIL h12_115959pm: got %0d:%0d:%0d pm=%b, expected 11:59:59 pm=1", hours, minutes, seconds, pm);
        end
        step(TICK_DIV);
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'd12, 6'd0, 6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL h12_midnight: got %0d:%0d:%0d pm=%b tick=%b, expected 12:0:0 pm=0 tick=1",
                     hours, minutes, seconds, pm, second_tick);
        end
    endtask
`endif

    task automatic test_mid_reset();
        preset(8, 30, 45);
        step(2);
        checks++;
        if ({hours, minutes, seconds, second_tick} !== {5'd8, 6'd30, 6'd45, 1'b0}) begin
            errors++;
            $display("FAIL mid_pre: got %0d:%0d:%0d tick=%b, expected 8:30:45 tick=0",
                     hours, minutes, seconds, second_tick);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({hours, minutes, seconds, pm, second_tick} !== {5'(RST_H), 6'd0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got %0d:%0d:%0d pm=%b tick=%b, expected %0d:0:0 pm=0 tick=0",
                     hours, minutes, seconds, pm, second_tick, RST_H);
        end
        #5 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
`ifndef TIME_KEEPER_12H_EN
        test_rollover();
        test_set_pulses();
`else
        test_12h();
`endif
        test_coincidence();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
